// File: rtl/enc32_5_pipe_pkg.sv
// Shared parameters and group-info type for the 32-to-5 priority encoder.
package enc_pkg;
  localparam int N      = 32;
  localparam int W      = 5;
  localparam int GROUPS = 4;
  localparam int CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-group summary produced by the 8-to-3 encoder in stage 1.
  typedef struct packed {
    logic       any;
    logic [2:0] loc;
    logic       mul;
  } grp_info_t;
endpackage

// File: rtl/enc32_5_pipe_if.sv
// Request/response bundle of the encoder; clk/reset stay outside.
interface enc32_5_pipe_if;
  import enc_pkg::*;
  logic             in_valid;
  logic [N-1:0]     in_vec;
  logic             stall;
  logic             clr_err;
  logic             out_valid;
  logic [W-1:0]     out_idx;
  logic             out_zero;
  logic             out_multi;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;

  modport master (output in_valid, in_vec, stall, clr_err,
                  input  out_valid, out_idx, out_zero, out_multi, err_sticky, err_count);
  modport slave  (input  in_valid, in_vec, stall, clr_err,
                  output out_valid, out_idx, out_zero, out_multi, err_sticky, err_count);
endinterface

// File: rtl/enc32_5_pipe_enc8_3.sv
// Combinational 8-to-3 lowest-set-bit encoder with empty / multi-hot flags.
module enc8_3
  import enc_pkg::*;
(
  input  logic [7:0] i_slice,
  output grp_info_t  o_info
);
  // Scan high to low so the lowest set bit wins; multi-hot when clearing
  // the lowest bit still leaves something set.
  always_comb begin
    o_info     = '0;
    o_info.any = |i_slice;
    o_info.mul = |(i_slice & (i_slice - 8'd1));
    for (int i = 7; i >= 0; i--)
      if (i_slice[i]) o_info.loc = 3'(i);
  end
endmodule

// File: rtl/enc32_5_pipe.sv
// Two-stage 32-to-5 priority encoder: stage 1 encodes 8-bit groups,
// stage 2 picks the lowest non-empty group; sticky/saturating error state.
module enc32_5_pipe
  import enc_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  enc32_5_pipe_if.slave  bus
);
  localparam int GW = W - 3;
  localparam int CW = $clog2(GROUPS + 1);

  grp_info_t [GROUPS-1:0] w_info;
  grp_info_t [GROUPS-1:0] r_s1_info;
  logic [1:0]             r_vld_pipe;
  logic [W-1:0]           r_idx;
  logic                   r_zero, r_multi;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;

  logic [GW-1:0]          w_gsel;
  logic [CW-1:0]          w_nany;
  logic [W-1:0]           w_idx;
  logic                   w_zero, w_multi, w_new_multi;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    enc8_3 u_enc (.i_slice(bus.in_vec[8*g +: 8]), .o_info(w_info[g]));
  end

  // Stage-2 select: lowest populated group, plus cross-group multi-hot check.
  always_comb begin
    w_gsel = '0;
    w_nany = '0;
    for (int g = GROUPS - 1; g >= 0; g--)
      if (r_s1_info[g].any) w_gsel = GW'(g);
    for (int g = 0; g < GROUPS; g++)
      w_nany = w_nany + CW'(r_s1_info[g].any);
    w_zero  = (w_nany == '0);
    w_idx   = {w_gsel, r_s1_info[w_gsel].loc};
    w_multi = r_s1_info[w_gsel].mul | (w_nany >= CW'(2));
  end

  // A beat is counted only on the edge it enters the output register.
  assign w_new_multi = ~bus.stall & r_vld_pipe[0] & w_multi;

  // Both pipeline stages; stall freezes everything including the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1_info  <= '0;
      r_idx      <= '0;
      r_zero     <= 1'b0;
      r_multi    <= 1'b0;
    end else if (!bus.stall) begin
      r_vld_pipe <= {r_vld_pipe[0], bus.in_valid};
      r_s1_info  <= w_info;
      r_idx      <= w_idx;
      r_zero     <= w_zero;
      r_multi    <= w_multi;
    end
  end

  // Error state: clear takes effect first, then an arriving multi-hot beat counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= 1'b0;
      r_cnt    <= '0;
    end else if (bus.clr_err) begin
      r_sticky <= w_new_multi;
      r_cnt    <= CNT_W'(w_new_multi);
    end else if (w_new_multi) begin
      r_sticky <= 1'b1;
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.out_valid  = r_vld_pipe[1];
  assign bus.out_idx    = r_idx;
  assign bus.out_zero   = r_zero;
  assign bus.out_multi  = r_multi;
  assign bus.err_sticky = r_sticky;
  assign bus.err_count  = r_cnt;
endmodule

// File: tb/tb_enc32_5_pipe.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them.
module tb_enc32_5_pipe;
  typedef struct packed {
    logic [4:0] idx;
    logic       zero;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t q[$];
  int m_cnt = 0;
  logic m_sticky = 1'b0;
  logic e_stall, e_clr;

  enc32_5_pipe_if bus();
  enc32_5_pipe dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: lowest set bit, emptiness, and population count >= 2.
  function automatic exp_t model(input logic [31:0] v);
    exp_t e;
    e.idx = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) e.idx = 5'(i);
    e.zero  = (v == 32'h0);
    e.multi = ($countones(v) >= 2);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic vl, input logic st, input logic cl);
    bus.in_vec = v; bus.in_valid = vl; bus.stall = st; bus.clr_err = cl;
    if (vl && !st) q.push_back(model(v));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin drive(32'h0, 1'b0, 1'b0, 1'b0); n++; end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
    end
  endtask

  // Edge-sampled control, so the monitor knows whether the last edge advanced.
  always @(posedge clk or posedge reset) begin
    if (reset) begin e_stall <= 1'b1; e_clr <= 1'b0; end
    else begin e_stall <= bus.stall; e_clr <= bus.clr_err; end
  end

  always @(negedge clk) begin
    if (reset) begin
      m_cnt = 0; m_sticky = 1'b0;
    end else begin
      if (e_clr) begin m_cnt = 0; m_sticky = 1'b0; end
      if (!e_stall && bus.out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat: idx=%0d with empty scoreboard", bus.out_idx);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat{idx,zero,multi}", {25'h0, bus.out_idx, bus.out_zero, bus.out_multi}, {25'h0, e});
          if (e.multi) begin
            m_sticky = 1'b1;
            if (m_cnt < 255) m_cnt++;
          end
        end
      end
      chk("err_count", {24'h0, bus.err_count}, 32'(m_cnt));
      chk("err_sticky", {31'h0, bus.err_sticky}, {31'h0, m_sticky});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    bus.in_vec = '0; bus.in_valid = 1'b0; bus.stall = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_idx", {27'h0, bus.out_idx}, 32'h0);
    chk("rst_out_zero", {31'h0, bus.out_zero}, 32'h0);
    chk("rst_out_multi", {31'h0, bus.out_multi}, 32'h0);
    chk("rst_err_sticky", {31'h0, bus.err_sticky}, 32'h0);
    chk("rst_err_count", {24'h0, bus.err_count}, 32'h0);
    reset = 1'b0;

    // Latency: accepted at edge k, visible after edge k+1.
    drive(32'h0000_0400, 1'b1, 1'b0, 1'b0);
    chk("lat_not_early", {31'h0, bus.out_valid}, 32'h0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("lat_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("lat_idx", {27'h0, bus.out_idx}, 32'd10);
    drain();

    // Walking one-hot, back to back.
    for (int i = 0; i < 32; i++) drive(32'h1 << i, 1'b1, 1'b0, 1'b0);
    drain();

    // Cross-group multi-hot then empty vector.
    drive(32'h0001_0010, 1'b1, 1'b0, 1'b0);
    drive(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();

    // Stall holds A at the output for 4 cycles, then B follows.
    drive(32'h2, 1'b1, 1'b0, 1'b0);
    drive(32'h100, 1'b1, 1'b0, 1'b0);
    chk("stall_a_idx", {27'h0, bus.out_idx}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1'b1, 1'b1, 1'b0);
      chk("stall_hold_idx", {27'h0, bus.out_idx}, 32'd1);
    end
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_b_idx", {27'h0, bus.out_idx}, 32'd8);
    drain();

    // Multi-hot beat held under stall is counted once (monitor model).
    drive(32'h3, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(32'h0, 1'b0, 1'b1, 1'b0);
    drain();

    // Saturation, then clear coinciding with an arriving multi-hot beat.
    for (int i = 0; i < 300; i++) drive(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drain();
    chk("sat_count", {24'h0, bus.err_count}, 32'd255);
    drive(32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drive(32'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_multi_count", {24'h0, bus.err_count}, 32'd1);
    chk("clr_multi_sticky", {31'h0, bus.err_sticky}, 32'h1);
    chk("allones_idx", {27'h0, bus.out_idx}, 32'd0);
    drive(32'h8000_0000, 1'b1, 1'b0, 1'b1);
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("top_bit_idx", {27'h0, bus.out_idx}, 32'd31);
    chk("clr_plain_count", {24'h0, bus.err_count}, 32'd0);
    drain();

    // Randomized traffic with stalls and occasional clears.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3))
        0: v = 32'h1 << $urandom_range(31);
        1: v = $urandom;
        2: v = 32'h0;
        default: v = (32'h1 << $urandom_range(31)) | (32'h1 << $urandom_range(31));
      endcase
      drive(v, ($urandom_range(3) != 0), ($urandom_range(4) == 0), ($urandom_range(19) == 0));
    end
    drain();

    // Asynchronous reset with two beats in flight.
    drive(32'h3, 1'b1, 1'b0, 1'b0);
    drive(32'h0003_0000, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_err_sticky", {31'h0, bus.err_sticky}, 32'h0);
    chk("arst_err_count", {24'h0, bus.err_count}, 32'h0);
    q.delete();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 6; i++) drive(32'h0, 1'b0, 1'b0, 1'b0);
    chk("arst_no_stale", {31'h0, bus.out_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enc32_5_pipe.md
Name: enc32_5_pipe

Overview:
Two-stage pipelined 32-to-5 priority encoder, the inverse of the register-file write-select decoder tree. It converts a 32-bit select vector back into a 5-bit register number. It flags vectors that are empty or multi-hot and keeps sticky and counting error state. It sits on the writeback and forwarding path, where register numbers are recovered from one-hot enables and checked for consistency.

Parameters:
N, 32, input vector width; must equal GROUPS*8.
W, 5, output index width; equals log2(N).
GROUPS, 4, number of 8-bit groups encoded in stage 1.
CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  in_vec is valid this cycle.
in_vec  input  N  select vector; bit i means register i.
stall  input  1  freezes both pipeline stages.
clr_err  input  1  synchronous clear of err_sticky and err_count.
out_valid  output  1  out_* are valid.
out_idx  output  W  index of the lowest set bit of the accepted vector; 0 when the vector is empty.
out_zero  output  1  accepted vector had no bits set.
out_multi  output  1  accepted vector had 2 or more bits set.
err_sticky  output  1  set by any out_valid beat with out_multi=1.
err_count  output  CNT_W  saturating count of out_multi beats.

Behaviour:
- Reset (asynchronous, any time, including mid-pipeline):
  - stage valids, out_valid, out_idx, out_zero, out_multi, err_sticky and err_count all go to 0.
  - In-flight data is discarded. The first accepted beat after reset deasserts appears 2 cycles later.
- Latency: vector accepted at edge k (in_valid=1, stall=0) appears on out_* after edge k+1. Throughput is 1 per cycle.
- Stage 1 register, per group g = 0..GROUPS-1, slice in_vec[8g+7:8g]:
  - any_g: OR of the slice.
  - loc_g: 3-bit index of the lowest set bit; 0 if the slice is empty.
  - mul_g: 2 or more bits set in the slice.
  - s1_valid <= in_valid.
- Stage 2 register:
  - gsel = lowest g with any_g=1.
  - out_idx <= {gsel[1:0], loc_gsel}.
  - out_zero <= no any_g set.
  - out_multi <= mul_gsel OR (count of set any_g >= 2).
  - out_valid <= s1_valid.
- Empty vector: out_idx=0, out_zero=1, out_multi=0. This is not an error; it is the legal "no write" case.
- Bubbles: in_valid=0 propagates as out_valid=0. out_idx, out_zero and out_multi still update, and their values are don't-care when out_valid=0.
- Stall=1: all stage registers, including out_*, hold their values. in_vec is ignored. Counters do not advance. A held out_valid beat is counted only once, in the cycle it first appears.
- Error logic:
  - Update on the edge where a new beat enters the output register with out_valid=1 and out_multi=1: err_sticky <= 1, err_count <= err_count+1, saturating at 2^CNT_W-1.
  - clr_err=1 sets both to 0, except when a multi-hot beat arrives on the same edge. In that case the result is err_sticky=1 and err_count=1: the clear is applied first, then the count.
  - clr_err is honoured even while stall=1.
- All-ones vector (0xFFFF_FFFF): out_idx=0, out_multi=1.
- Vector 0x8000_0000: out_idx=31, out_zero=0, out_multi=0.

Decomposition:
- Package enc_pkg holds N, W, GROUPS, CNT_W, the localparam CNT_MAX, and typedef grp_info_t (struct: any, loc[2:0], mul).
- One sub-module, enc8_3: a combinational 8-to-3 lowest-bit priority encoder producing grp_info_t. It is instantiated GROUPS times in stage 1.
- Stage-2 group select, both pipeline registers and the error counter live in enc32_5_pipe itself.

Test Plan:
- Hold reset high, then release; drive in_vec=0x0000_0400, in_valid=1 for 1 cycle -> 2 cycles later out_valid=1, out_idx=10, out_zero=0, out_multi=0; err_count=0.
- Drive 32 consecutive one-hot vectors 1<<i, i=0..31, back-to-back -> out_idx sequence 0..31 with no gaps, out_multi=0 throughout.
- Drive in_vec=0x0001_0010 (bits 4 and 16) -> out_idx=4, out_multi=1, err_sticky=1, err_count=1. Then in_vec=0x0000_0000 -> out_zero=1, out_idx=0, err_count remains 1.
- Drive vector A=0x2, then vector B=0x100, with stall=1 for 3 cycles while A is at the output -> out_idx holds 1 for 4 cycles, then becomes 8. A multi-hot beat held under stall increments err_count exactly once.
- Drive 300 consecutive 0xFFFF_FFFF beats -> err_count saturates at 255. Then assert clr_err on the same edge a multi-hot beat arrives -> err_count=1, err_sticky=1.
- With 2 valid beats in flight, assert reset asynchronously mid-cycle -> out_valid, err_sticky and err_count go to 0 immediately; no stale beat emerges after reset releases.
